mem_stage_ctrl: RTL

- Consumer end of the EX→MEM pipeline latch: takes the registered execute-stage outputs and performs the data-memory access.
- Drives a request/ready data-memory port, handling byte/word lanes, alignment and timeouts.
- Presents results to the write-back stage.
- Asserts a stall back toward the pipeline while a memory access is outstanding.

---
 rtl/mem_stage_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: turns the registered EX results into a data-memory access over a
// request/ready port and hands aligned results (or bubbles) to write-back.
module mem_stage_ctrl #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write_en_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_num_in,
    input  logic        is_mem_inst_in,
    input  logic        is_word_in,
    input  logic        halted_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [4:0]  wb_rd_num,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_load_data,
    output logic        wb_halted,
    output logic        mem_error
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    // Counter value seen on the last ACCESS cycle before giving up.
    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        err_q, err_d;
    logic        capture_en;

    logic        we_q, to_reg_q, reg_write_q, is_word_q, halted_q;
    logic [31:0] addr_q, sdata_q;
    logic [4:0]  rd_q;

    logic        wb_reg_write_q, wb_reg_write_d;
    logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [4:0]  wb_rd_num_q, wb_rd_num_d;
    logic [31:0] wb_alu_result_q, wb_alu_result_d;
    logic [31:0] wb_load_data_q, wb_load_data_d;
    logic        wb_halted_q, wb_halted_d;

    logic        misaligned;
    logic [7:0]  lane_byte;
    logic [31:0] load_value;

    assign misaligned = is_word_in && (alu_result_in[1:0] != 2'b00);

    always_comb begin
        lane_byte = 8'h00;
        case (addr_q[1:0])
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
    end

    always_comb begin
        load_value = 32'h0;
        if (!we_q) begin
            load_value = is_word_q ? mem_rdata : {{24{lane_byte[7]}}, lane_byte};
        end
    end

    always_comb begin
        state_d         = state_q;
        wait_d          = wait_q;
        err_d           = err_q;
        capture_en      = 1'b0;
        wb_reg_write_d  = 1'b0;
        wb_mem_to_reg_d = 1'b0;
        wb_rd_num_d     = 5'd0;
        wb_alu_result_d = 32'h0;
        wb_load_data_d  = 32'h0;
        wb_halted_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (!is_mem_inst_in) begin
                    wb_reg_write_d  = reg_write_in;
                    wb_mem_to_reg_d = mem_to_reg_in;
                    wb_rd_num_d     = rd_num_in;
                    wb_alu_result_d = alu_result_in;
                    wb_halted_d     = halted_in;
                end else if (misaligned) begin
                    err_d       = 1'b1;
                    wb_halted_d = 1'b1;
                end else begin
                    capture_en = 1'b1;
                    wait_d     = 8'd0;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                if (mem_ready) begin
                    wb_reg_write_d  = reg_write_q;
                    wb_mem_to_reg_d = to_reg_q;
                    wb_rd_num_d     = rd_q;
                    wb_alu_result_d = addr_q;
                    wb_load_data_d  = load_value;
                    wb_halted_d     = halted_q;
                    state_d         = StIdle;
                end else if (wait_q == WaitLast) begin
                    err_d       = 1'b1;
                    wb_halted_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            wait_q          <= 8'd0;
            err_q           <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rd_num_q     <= 5'd0;
            wb_alu_result_q <= 32'h0;
            wb_load_data_q  <= 32'h0;
            wb_halted_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            err_q           <= err_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_rd_num_q     <= wb_rd_num_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_load_data_q  <= wb_load_data_d;
            wb_halted_q     <= wb_halted_d;
        end
    end

    // Fields of the instruction in flight; frozen for the whole ACCESS phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q        <= 1'b0;
            to_reg_q    <= 1'b0;
            reg_write_q <= 1'b0;
            is_word_q   <= 1'b0;
            halted_q    <= 1'b0;
            addr_q      <= 32'h0;
            sdata_q     <= 32'h0;
            rd_q        <= 5'd0;
        end else if (capture_en) begin
            we_q        <= mem_write_en_in;
            to_reg_q    <= mem_to_reg_in;
            reg_write_q <= reg_write_in;
            is_word_q   <= is_word_in;
            halted_q    <= halted_in;
            addr_q      <= alu_result_in;
            sdata_q     <= store_data_in;
            rd_q        <= rd_num_in;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        mem_byte_en = 4'b0000;
        if (state_q == StAccess) begin
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = addr_q;
            if (is_word_q) begin
                mem_byte_en = 4'b1111;
                mem_wdata   = sdata_q;
            end else begin
                mem_byte_en = 4'b0001 << addr_q[1:0];
                mem_wdata   = {4{sdata_q[7:0]}};
            end
        end
    end

    assign stall         = (state_q == StAccess);
    assign mem_error     = err_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_rd_num     = wb_rd_num_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_load_data  = wb_load_data_q;
    assign wb_halted     = wb_halted_q;

endmodule
